// File: rtl/la_route_pipe.sv
// Two-stage lookahead route computation for the bufferless mesh router.
// Stage 1 resolves the next-hop coordinate and error flags; stage 2 forms the neighbour's preferred-port vector.
module la_route_pipe #(
    parameter int NUM_CH   = 4,
    parameter int NUM_PORT = 5,
    parameter int COORD_W  = 3,
    parameter int MESH_X   = 8,
    parameter int MESH_Y   = 8,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0,
    parameter int DST_W    = 2 * COORD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode_i,
    input  logic                       hold_i,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DST_W-1:0]    in_dst,
    input  logic [NUM_CH*2-1:0]        in_outdir,
    output logic [NUM_CH-1:0]          out_valid,
    output logic [NUM_CH*NUM_PORT-1:0] out_ppv,
    output logic [NUM_CH*DST_W-1:0]    out_dst,
    output logic [NUM_CH-1:0]          out_err,
    output logic [7:0]                 err_cnt
);

    // One spare bit so a step off either mesh edge lands at or above the mesh size.
    localparam int NW = COORD_W + 1;
    localparam logic [NW-1:0] CX = NW'(CUR_X);
    localparam logic [NW-1:0] CY = NW'(CUR_Y);
    localparam logic [NW-1:0] MX = NW'(MESH_X);
    localparam logic [NW-1:0] MY = NW'(MESH_Y);

    localparam logic [1:0] DIR_N   = 2'd0;
    localparam logic [1:0] DIR_E   = 2'd1;
    localparam logic [1:0] DIR_S   = 2'd2;
    localparam logic [1:0] MODE_YX = 2'd1;
    localparam logic [1:0] MODE_AD = 2'd2;

    function automatic logic [NUM_PORT-1:0] route_ppv(
        input logic [1:0]    mode,
        input logic [NW-1:0] dx, dy, nx, ny
    );
        logic gx, lx, gy, ly;
        logic [NUM_PORT-1:0] p;
        gx = dx > nx;
        lx = dx < nx;
        gy = dy > ny;
        ly = dy < ny;
        p  = '0;
        case (mode)
            MODE_YX: begin
                p[0] = gy;
                p[2] = ly;
                p[1] = gx && !gy && !ly;
                p[3] = lx && !gy && !ly;
            end
            MODE_AD: begin
                p[0] = gy;
                p[1] = gx;
                p[2] = ly;
                p[3] = lx;
            end
            default: begin
                p[1] = gx;
                p[3] = lx;
                p[0] = gy && !gx && !lx;
                p[2] = ly && !gx && !lx;
            end
        endcase
        p[4] = (dx == nx) && (dy == ny);
        return p;
    endfunction

    function automatic int unsigned err_pop(input logic [NUM_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_CH; i++) n += 32'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] acc, input int unsigned inc);
        int unsigned sum;
        sum = 32'(acc) + inc;
        return (sum > 32'd255) ? 8'd255 : sum[7:0];
    endfunction

    logic             vld_p1  [NUM_CH];
    logic [DST_W-1:0] dst_p1  [NUM_CH];
    logic [1:0]       mode_p1 [NUM_CH];
    logic [NW-1:0]    nx_p1   [NUM_CH];
    logic [NW-1:0]    ny_p1   [NUM_CH];
    logic             off_p1  [NUM_CH];
    logic             rng_p1  [NUM_CH];

    logic [NW-1:0]    nx_d    [NUM_CH];
    logic [NW-1:0]    ny_d    [NUM_CH];
    logic             off_d   [NUM_CH];
    logic             rng_d   [NUM_CH];

    logic [NUM_CH-1:0]          vld_p2, vld_d, err_p2, err_d;
    logic [NUM_CH*NUM_PORT-1:0] ppv_p2, ppv_d;
    logic [NUM_CH*DST_W-1:0]    dst_p2, dst_d;
    logic [7:0]                 cnt_p2;

    // Stage 0 -> 1: neighbour coordinate and error flags
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            nx_d[c] = CX;
            ny_d[c] = CY;
            case (in_outdir[c*2 +: 2])
                DIR_N:   ny_d[c] = CY + NW'(1);
                DIR_E:   nx_d[c] = CX + NW'(1);
                DIR_S:   ny_d[c] = CY - NW'(1);
                default: nx_d[c] = CX - NW'(1);
            endcase
            off_d[c] = (nx_d[c] >= MX) || (ny_d[c] >= MY);
            rng_d[c] = ({1'b0, in_dst[c*DST_W +: COORD_W]} >= MX) ||
                       ({1'b0, in_dst[c*DST_W+COORD_W +: COORD_W]} >= MY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) vld_p1[c] <= 1'b0;
        end else if (!hold_i) begin
            for (int c = 0; c < NUM_CH; c++) vld_p1[c] <= in_valid[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!hold_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                dst_p1[c]  <= in_dst[c*DST_W +: DST_W];
                mode_p1[c] <= mode_i;
                nx_p1[c]   <= nx_d[c];
                ny_p1[c]   <= ny_d[c];
                off_p1[c]  <= off_d[c];
                rng_p1[c]  <= rng_d[c];
            end
        end
    end

    // Stage 1 -> 2: preferred-port vector at the neighbour
    always_comb begin
        vld_d = '0;
        err_d = '0;
        ppv_d = '0;
        dst_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            vld_d[c] = vld_p1[c];
            err_d[c] = vld_p1[c] && (off_p1[c] || rng_p1[c]);
            dst_d[c*DST_W +: DST_W] = dst_p1[c];
            if (vld_p1[c] && !err_d[c])
                ppv_d[c*NUM_PORT +: NUM_PORT] = route_ppv(mode_p1[c],
                    {1'b0, dst_p1[c][COORD_W-1:0]},
                    {1'b0, dst_p1[c][2*COORD_W-1:COORD_W]},
                    nx_p1[c], ny_p1[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= '0;
            err_p2 <= '0;
            ppv_p2 <= '0;
            dst_p2 <= '0;
            cnt_p2 <= '0;
        end else if (!hold_i) begin
            vld_p2 <= vld_d;
            err_p2 <= err_d;
            ppv_p2 <= ppv_d;
            dst_p2 <= dst_d;
            cnt_p2 <= sat_add(cnt_p2, err_pop(err_d));
        end
    end

    assign out_valid = vld_p2;
    assign out_err   = err_p2;
    assign out_ppv   = ppv_p2;
    assign out_dst   = dst_p2;
    assign err_cnt   = cnt_p2;

endmodule

// File: tb/tb_la_route_pipe.sv
// Bench for la_route_pipe: two instances (router (3,3) with 3-bit coords, router (7,7) with 4-bit coords)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_la_route_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, hold;
    logic [1:0]  a_mode, b_mode;
    logic [3:0]  a_valid, b_valid;
    logic [23:0] a_dst;
    logic [31:0] b_dst;
    logic [7:0]  a_dir, b_dir;
    logic [3:0]  a_out_valid, a_out_err, b_out_valid, b_out_err;
    logic [19:0] a_out_ppv, b_out_ppv;
    logic [23:0] a_out_dst;
    logic [31:0] b_out_dst;
    logic [7:0]  a_cnt, b_cnt;

    la_route_pipe #(.NUM_CH(4), .NUM_PORT(5), .COORD_W(3), .MESH_X(8), .MESH_Y(8),
                    .CUR_X(3), .CUR_Y(3), .DST_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode_i(a_mode), .hold_i(hold),
        .in_valid(a_valid), .in_dst(a_dst), .in_outdir(a_dir),
        .out_valid(a_out_valid), .out_ppv(a_out_ppv), .out_dst(a_out_dst),
        .out_err(a_out_err), .err_cnt(a_cnt));

    la_route_pipe #(.NUM_CH(4), .NUM_PORT(5), .COORD_W(4), .MESH_X(8), .MESH_Y(8),
                    .CUR_X(7), .CUR_Y(7), .DST_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode_i(b_mode), .hold_i(hold),
        .in_valid(b_valid), .in_dst(b_dst), .in_outdir(b_dir),
        .out_valid(b_out_valid), .out_ppv(b_out_ppv), .out_dst(b_out_dst),
        .out_err(b_out_err), .err_cnt(b_cnt));

    int st_v[2][4], st_dir[2][4], st_x[2][4], st_y[2][4], st_mode[2];

    always_comb begin
        a_valid = '0; b_valid = '0; a_dir = '0; b_dir = '0; a_dst = '0; b_dst = '0;
        a_mode = 2'(st_mode[0]);
        b_mode = 2'(st_mode[1]);
        for (int c = 0; c < 4; c++) begin
            a_valid[c] = (st_v[0][c] != 0);
            b_valid[c] = (st_v[1][c] != 0);
            a_dir[c*2 +: 2] = 2'(st_dir[0][c]);
            b_dir[c*2 +: 2] = 2'(st_dir[1][c]);
            a_dst[c*6 +: 6] = {3'(st_y[0][c]), 3'(st_x[0][c])};
            b_dst[c*8 +: 8] = {4'(st_y[1][c]), 4'(st_x[1][c])};
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Route of one flit from first principles on an 8x8 mesh, with signed neighbour coordinates.
    function automatic void route_model(input int cx, input int cy, input int mode, input int dir,
                                        input int x, input int y, output int ppv, output int err);
        int nx, ny;
        nx = cx; ny = cy;
        if (dir == 0) ny = cy + 1;
        else if (dir == 1) nx = cx + 1;
        else if (dir == 2) ny = cy - 1;
        else nx = cx - 1;
        err = (nx < 0 || nx > 7 || ny < 0 || ny > 7 || x > 7 || y > 7) ? 1 : 0;
        ppv = 0;
        if (err != 0) return;
        if (x == nx && y == ny) ppv = 16;
        else if (mode == 2) ppv = (y > ny ? 1 : 0) | (x > nx ? 2 : 0) | (y < ny ? 4 : 0) | (x < nx ? 8 : 0);
        else if (mode == 1) ppv = (y != ny) ? (y > ny ? 1 : 4) : (x > nx ? 2 : 8);
        else ppv = (x != nx) ? (x > nx ? 2 : 8) : (y > ny ? 1 : 4);
    endfunction

    int m1_v[2][4], m1_p[2][4], m1_e[2][4], m1_d[2][4];
    int mo_v[2][4], mo_p[2][4], mo_e[2][4], mo_d[2][4];
    int mcnt[2];

    always @(posedge clk or negedge rst_n) begin
        int p, e, inc, cw, cur;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mcnt[d] = 0;
                for (int c = 0; c < 4; c++) begin
                    m1_v[d][c] = 0; m1_p[d][c] = 0; m1_e[d][c] = 0; m1_d[d][c] = 0;
                    mo_v[d][c] = 0; mo_p[d][c] = 0; mo_e[d][c] = 0; mo_d[d][c] = 0;
                end
            end
        end else if (!hold) begin
            for (int d = 0; d < 2; d++) begin
                cw  = (d == 1) ? 4 : 3;
                cur = (d == 1) ? 7 : 3;
                inc = 0;
                for (int c = 0; c < 4; c++) inc += m1_e[d][c];
                mcnt[d] = (mcnt[d] + inc > 255) ? 255 : mcnt[d] + inc;
                for (int c = 0; c < 4; c++) begin
                    mo_v[d][c] = m1_v[d][c]; mo_p[d][c] = m1_p[d][c];
                    mo_e[d][c] = m1_e[d][c]; mo_d[d][c] = m1_d[d][c];
                    route_model(cur, cur, st_mode[d], st_dir[d][c], st_x[d][c], st_y[d][c], p, e);
                    m1_v[d][c] = (st_v[d][c] != 0) ? 1 : 0;
                    m1_e[d][c] = (m1_v[d][c] != 0) ? e : 0;
                    m1_p[d][c] = (m1_v[d][c] != 0 && e == 0) ? p : 0;
                    m1_d[d][c] = (st_y[d][c] << cw) | st_x[d][c];
                end
            end
        end
    end

    task automatic cmp_dut(input string tag, input int d, input logic [31:0] v, input logic [31:0] p,
                           input logic [31:0] e, input logic [31:0] dd, input logic [31:0] cnt);
        logic [31:0] ev, ep, ee, ed, md;
        int cw;
        cw = (d == 1) ? 4 : 3;
        ev = '0; ep = '0; ee = '0; ed = '0; md = '0;
        for (int c = 0; c < 4; c++) begin
            ev[c] = (mo_v[d][c] != 0);
            ee[c] = (mo_e[d][c] != 0);
            ep[c*5 +: 5] = 5'(mo_p[d][c]);
            if (mo_v[d][c] != 0) begin
                ed = ed | (32'(mo_d[d][c]) << (c*2*cw));
                md = md | (((32'd1 << (2*cw)) - 32'd1) << (c*2*cw));
            end
        end
        cmp({tag, " valid"}, v, ev);
        cmp({tag, " err"}, e, ee);
        cmp({tag, " ppv"}, p, ep);
        cmp({tag, " dst"}, dd & md, ed);
        cmp({tag, " err_cnt"}, cnt, 32'(mcnt[d]));
    endtask

    bit chk_en = 1'b0;
    bit cap_en = 1'b0;
    int cap_q[$];

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp_dut("A", 0, 32'(a_out_valid), 32'(a_out_ppv), 32'(a_out_err), 32'(a_out_dst), 32'(a_cnt));
            cmp_dut("B", 1, 32'(b_out_valid), 32'(b_out_ppv), 32'(b_out_err), b_out_dst, 32'(b_cnt));
            if (cap_en && a_out_valid[0] && !hold) cap_q.push_back(int'(a_out_dst[2:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                st_v[d][c] = 0; st_dir[d][c] = 0; st_x[d][c] = 0; st_y[d][c] = 0;
            end
    endtask

    task automatic put(input int d, input int c, input int dir, input int x, input int y);
        st_v[d][c] = 1; st_dir[d][c] = dir; st_x[d][c] = x; st_y[d][c] = y;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] snap_p;
        logic [23:0] snap_d;
        rst_n = 1'b0;
        hold = 1'b0;
        st_mode[0] = 0; st_mode[1] = 0;
        clear_in();
        repeat (3) tick();
        cmp("reset a_out_valid", 32'(a_out_valid), 32'd0);
        cmp("reset b_err_cnt", 32'(b_cnt), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // XY: neighbour (4,3), dst (6,1) -> East
        put(0, 0, 1, 6, 1);
        tick(); clear_in(); tick();
        cmp("xy ppv", 32'(a_out_ppv[4:0]), 32'b00010);
        cmp("xy valid", 32'(a_out_valid[0]), 32'd1);
        cmp("xy err", 32'(a_out_err[0]), 32'd0);

        // Same flit with the mode changing every cycle
        st_mode[0] = 1; put(0, 0, 1, 6, 1); tick();
        st_mode[0] = 2; tick();
        cmp("yx ppv", 32'(a_out_ppv[4:0]), 32'b00100);
        st_mode[0] = 0; tick();
        cmp("adaptive ppv", 32'(a_out_ppv[4:0]), 32'b00110);
        clear_in(); tick();
        cmp("xy again ppv", 32'(a_out_ppv[4:0]), 32'b00010);
        tick();

        // Every channel aimed at its own neighbour -> Local
        put(0, 0, 1, 4, 3); put(0, 1, 0, 3, 4); put(0, 2, 2, 3, 2); put(0, 3, 3, 2, 3);
        tick(); clear_in(); tick();
        cmp("local ppv", 32'(a_out_ppv), 32'({4{5'b10000}}));
        cmp("local valid", 32'(a_out_valid), 32'hF);
        tick();

        // Router (7,7): North leaves the mesh, dst x=9 is out of range
        put(1, 0, 0, 1, 1); put(1, 1, 3, 9, 0);
        tick(); clear_in(); tick();
        cmp("err flags", 32'(b_out_err), 32'b0011);
        cmp("err ppv", 32'(b_out_ppv), 32'd0);
        cmp("err valid", 32'(b_out_valid), 32'b0011);
        cmp("err_cnt +2", 32'(b_cnt), 32'd2);

        repeat (63) begin
            for (int c = 0; c < 4; c++) put(1, c, 0, 0, 0);
            tick();
        end
        clear_in(); tick();
        cmp("err_cnt 254", 32'(b_cnt), 32'd254);
        for (int c = 0; c < 4; c++) put(1, c, 0, 0, 0);
        tick(); clear_in(); tick();
        cmp("err_cnt clamp", 32'(b_cnt), 32'd255);
        for (int c = 0; c < 4; c++) put(1, c, 0, 0, 0);
        tick(); clear_in(); tick();
        cmp("err_cnt stays", 32'(b_cnt), 32'd255);
        tick();

        // Five-flit stream with a three-cycle hold
        cap_en = 1'b1;
        put(0, 0, 1, 1, 1); tick();
        put(0, 0, 1, 2, 2); tick();
        put(0, 0, 1, 3, 3); hold = 1'b1;
        snap_p = a_out_ppv; snap_d = a_out_dst;
        repeat (3) begin
            tick();
            cmp("hold ppv stable", 32'(a_out_ppv), 32'(snap_p));
            cmp("hold dst stable", 32'(a_out_dst), 32'(snap_d));
        end
        hold = 1'b0; tick();
        put(0, 0, 1, 4, 4); tick();
        put(0, 0, 1, 5, 5); tick();
        clear_in();
        repeat (3) tick();
        cap_en = 1'b0;
        cmp("stream count", 32'(cap_q.size()), 32'd5);
        for (int i = 0; i < cap_q.size() && i < 5; i++) cmp("stream order", 32'(cap_q[i]), 32'(i + 1));

        // Asynchronous reset with two flits in flight
        put(0, 0, 1, 6, 1); tick();
        put(0, 0, 1, 4, 3); tick();
        clear_in();
        #2 rst_n = 1'b0;
        #1;
        cmp("rst out_valid", 32'(a_out_valid), 32'd0);
        cmp("rst out_ppv", 32'(a_out_ppv), 32'd0);
        cmp("rst out_dst", 32'(a_out_dst), 32'd0);
        cmp("rst b err_cnt", 32'(b_cnt), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            cmp("post-reset valid", 32'(a_out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
